// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write-port bundle for imem_loader.
// master = loader side, slave = stream source / memory side.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, we, waddr, wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: reads a little-endian length N and N words from a byte stream, writes them to IMEM.
// Optional trailing checksum stage enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  imem_loader_if.master      bus,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               cpu_rst,
  output logic [31:0]        word_count
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, LEN = 3'd1, DATA = 3'd2, DONE = 3'd3, ERR = 3'd4, CHK = 3'd5
  } state_t;
  localparam state_t LOAD_END = CHK;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, LEN = 3'd1, DATA = 3'd2, DONE = 3'd3, ERR = 3'd4
  } state_t;
  localparam state_t LOAD_END = DONE;
`endif

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      state_r;
  state_t      next_state_s;
  logic [1:0]  byte_cnt_r;
  logic [31:0] shift_r;
  logic [31:0] word_idx_r;
  logic [31:0] word_count_r;
  logic        byte_ready_r;
  logic        we_r;
  logic [31:0] waddr_r;
  logic [31:0] wdata_r;
  logic        busy_r;
  logic        done_r;
  logic        err_r;
  logic        cpu_rst_r;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_r;
`endif

  logic        accept_s;
  logic        word_end_s;
  logic        last_word_s;
  logic        start_load_s;
  logic [31:0] word_s;

  assign accept_s     = bus.byte_valid & byte_ready_r;
  assign word_end_s   = accept_s & (byte_cnt_r == 2'd3);
  // Newest byte enters at the top, so after four shifts the first byte sits in bits 7:0.
  assign word_s       = {bus.byte_data, shift_r[31:8]};
  assign last_word_s  = (word_idx_r == (word_count_r - 32'd1));
  assign start_load_s = start & ((state_r == IDLE) | (state_r == DONE) | (state_r == ERR));

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE, DONE, ERR: begin
        if (start) next_state_s = LEN;
        else       next_state_s = state_r;
      end
      LEN: begin
        if (!word_end_s)              next_state_s = LEN;
        else if (word_s == 32'd0)     next_state_s = LOAD_END;
        else if (word_s > DEPTH_W)    next_state_s = ERR;
        else                          next_state_s = DATA;
      end
      DATA: begin
        if (word_end_s && last_word_s) next_state_s = LOAD_END;
        else                           next_state_s = DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (!word_end_s)          next_state_s = CHK;
        else if (word_s == sum_r) next_state_s = DONE;
        else                      next_state_s = ERR;
      end
`endif
      default: next_state_s = IDLE;
    endcase
  end

  // State register and registered status outputs decoded from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      byte_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      cpu_rst_r    <= 1'b1;
    end else begin
      state_r      <= next_state_s;
`ifdef LOADER_CHECKSUM_EN
      byte_ready_r <= (next_state_s == LEN) | (next_state_s == DATA) | (next_state_s == CHK);
      busy_r       <= (next_state_s == LEN) | (next_state_s == DATA) | (next_state_s == CHK);
`else
      byte_ready_r <= (next_state_s == LEN) | (next_state_s == DATA);
      busy_r       <= (next_state_s == LEN) | (next_state_s == DATA);
`endif
      done_r       <= (next_state_s == DONE);
      err_r        <= (next_state_s == ERR);
      cpu_rst_r    <= (next_state_s != DONE);
    end
  end

  // Byte assembly, length latch, write pulse and running sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_r   <= 2'd0;
      shift_r      <= 32'd0;
      word_idx_r   <= 32'd0;
      word_count_r <= 32'd0;
      we_r         <= 1'b0;
      waddr_r      <= 32'd0;
      wdata_r      <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      sum_r        <= 32'd0;
`endif
    end else begin
      we_r <= 1'b0;
      if (start_load_s) begin
        byte_cnt_r   <= 2'd0;
        shift_r      <= 32'd0;
        word_idx_r   <= 32'd0;
        word_count_r <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
        sum_r        <= 32'd0;
`endif
      end else if (accept_s) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        shift_r    <= word_s;
        if (word_end_s && (state_r == LEN)) begin
          word_count_r <= word_s;
        end else if (word_end_s && (state_r == DATA)) begin
          we_r    <= 1'b1;
          waddr_r <= BASE_ADDR + (word_idx_r << 2);
          wdata_r <= word_s;
`ifdef LOADER_CHECKSUM_EN
          sum_r   <= sum_r + word_s;
`endif
          // Index stops at the last word so it never passes DEPTH-1.
          if (!last_word_s) word_idx_r <= word_idx_r + 32'd1;
        end
      end
    end
  end

  assign bus.byte_ready = byte_ready_r;
  assign bus.we         = we_r;
  assign bus.waddr      = waddr_r;
  assign bus.wdata      = wdata_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign err            = err_r;
  assign cpu_rst        = cpu_rst_r;
  assign word_count     = word_count_r;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a word-level reference model.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int unsigned  DEPTH = 256;
  localparam logic [31:0]  BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, err, cpu_rst;
  logic [31:0] word_count;

  imem_loader_if bus();

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .err(err), .cpu_rst(cpu_rst), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] words_q[$];
  logic [7:0]  stream_q[$];

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.we) begin
      wr_addr_q.push_back(bus.waddr);
      wr_data_q.push_back(bus.wdata);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    stream_q.push_back(w[7:0]);
    stream_q.push_back(w[15:8]);
    stream_q.push_back(w[23:16]);
    stream_q.push_back(w[31:24]);
  endtask

  // Byte stream: length, then the words (only when in range), then optional checksum.
  task automatic build_stream(input logic [31:0] n, input bit bad_sum);
    logic [31:0] sum;
    stream_q = {};
    push_word(n);
    sum = 32'd0;
    if (n <= DEPTH) begin
      foreach (words_q[i]) begin
        push_word(words_q[i]);
        sum = sum + words_q[i];
      end
`ifdef LOADER_CHECKSUM_EN
      push_word(bad_sum ? sum + 32'd1 : sum);
`endif
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_done"}, {31'd0, done}, 32'd0);
    check_val({tag, "_err"}, {31'd0, err}, 32'd0);
    check_val({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    check_val({tag, "_word_count"}, word_count, 32'd0);
    check_val({tag, "_ready"}, {31'd0, bus.byte_ready}, 32'd0);
    check_val({tag, "_we"}, {31'd0, bus.we}, 32'd0);
    check_val({tag, "_waddr"}, bus.waddr, 32'd0);
    check_val({tag, "_wdata"}, bus.wdata, 32'd0);
  endtask

  task automatic pulse_start(input string tag);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_val({tag, "_busy_on"}, {31'd0, busy}, 32'd1);
    check_val({tag, "_cpu_rst_on"}, {31'd0, cpu_rst}, 32'd1);
  endtask

  // Feeds up to max_bytes of stream_q; gap 0 = gapless, 1 = alternate cycles, 2 = random.
  task automatic feed(input int max_bytes, input int gap, input bit poke_start, output int sent);
    int cyc;
    bit v;
    sent = 0;
    cyc  = 0;
    while (sent < max_bytes && cyc < 8 * max_bytes + 20) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      bus.byte_valid = v;
      bus.byte_data  = stream_q[sent];
      start          = poke_start && (sent == 5);
      if (v && bus.byte_ready) sent++;
      @(negedge clk);
      cyc++;
    end
    bus.byte_valid = 1'b0;
    start          = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [31:0] n, input int gap,
                          input bit bad_sum, input bit poke_start);
    int  sent, cyc, nexp;
    bit  exp_err;
    build_stream(n, bad_sum);
    exp_err = (n > DEPTH);
`ifdef LOADER_CHECKSUM_EN
    exp_err = exp_err || bad_sum;
`endif
    nexp = (n > DEPTH) ? 0 : int'(n);
    pulse_start(tag);
    feed(stream_q.size(), gap, poke_start, sent);
    check_val({tag, "_sent"}, sent, stream_q.size());
    cyc = 0;
    while (!(done || err) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    @(negedge clk);
    check_val({tag, "_done"}, {31'd0, done}, {31'd0, !exp_err});
    check_val({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, exp_err});
    check_val({tag, "_word_count"}, word_count, n);
    check_val({tag, "_nwr"}, wr_addr_q.size(), nexp);
    for (int k = 0; k < nexp && k < wr_addr_q.size(); k++) begin
      check_val($sformatf("%s_waddr%0d", tag, k), wr_addr_q[k], BASE + 32'(4 * k));
      check_val($sformatf("%s_wdata%0d", tag, k), wr_data_q[k], words_q[k]);
    end
    wr_addr_q = {};
    wr_data_q = {};
  endtask

  task automatic rand_words(input int n);
    words_q = {};
    for (int i = 0; i < n; i++) words_q.push_back($urandom());
  endtask

  initial begin
    int sent, n;
    rst            = 1'b1;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    #1;
    check_reset("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    words_q = {32'h0000_0013, 32'h0010_0093};
    run_load("gapless", 32'd2, 0, 1'b0, 1'b0);
    run_load("throttled", 32'd2, 1, 1'b0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    run_load("badsum", 32'd2, 0, 1'b1, 1'b0);
`endif

    rand_words(256);
    run_load("full256", 32'd256, 0, 1'b0, 1'b0);
    words_q = {};
    run_load("over257", 32'd257, 0, 1'b0, 1'b0);
    run_load("empty", 32'd0, 0, 1'b0, 1'b0);

    words_q = {32'h0000_0013, 32'h0010_0093};
    build_stream(32'd2, 1'b0);
    pulse_start("abort");
    feed(6, 0, 1'b0, sent);
    rst = 1'b1;
    @(negedge clk);
    check_reset("abort_rst");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_val("abort_nowr", wr_addr_q.size(), 32'd0);
    run_load("reload", 32'd2, 0, 1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 16);
      rand_words(n);
      run_load($sformatf("rand%0d", t), 32'(n), 2, ($urandom_range(0, 3) == 0), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
